// File: rtl/ip_psram_arbiter_pkg.sv
// Purpose : shared types and constants for the PSRAM arbiter slice.
// Contents: requester count, bus widths, FSM state encoding, request slot
//           record and the round-robin index step helper.
package ip_psram_arbiter_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned GNT_W   = 2;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  // (base + step) mod NUM_REQ as a requester index.
  function automatic logic [GNT_W-1:0] rr_step(input logic [GNT_W-1:0] base,
                                               input int unsigned     step);
    int unsigned idx;
    idx = (32'(base) + step) % NUM_REQ;
    return idx[GNT_W-1:0];
  endfunction

endpackage

// File: rtl/ip_psram_arb_rr.sv
// Purpose : 3-way round-robin pick; searches from last_grant+1 upward (mod 3).
// Latency : combinational.  Backpressure: none, pure function of its inputs.
// Ports   : pending_i (request vector), last_grant_i -> grant_vld_o, grant_o.
module ip_psram_arb_rr
  import ip_psram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [GNT_W-1:0]   last_grant_i,
  output logic               grant_vld_o,
  output logic [GNT_W-1:0]   grant_o
);

  logic [GNT_W-1:0] cand;

  always_comb begin
    grant_vld_o = 1'b0;
    grant_o     = last_grant_i;
    cand        = '0;
    // Nearest pending requester after last_grant wins; last_grant itself is
    // considered last so a lone requester can still be served back to back.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = rr_step(last_grant_i, k);
      if (!grant_vld_o && pending_i[cand]) begin
        grant_vld_o = 1'b1;
        grant_o     = cand;
      end
    end
  end

endmodule

// File: rtl/ip_psram_arbiter.sv
// Purpose : arbitrates three single-beat requesters onto one PSRAM port.
// Latency : strobe at t -> rd/wr at t+2; completion pulse one cycle after the
//           PSRAM drops busy (or after TIMEOUT WAIT cycles).
// Backpressure: req_busy[i] high means further strobes from i are dropped.
// Ports   : clk/reset; req_rd/req_wr/req_address/req_wdata in, req_busy,
//           req_rdata, req_rdata_en, timeout_err out; rd/wr/address/wdata to
//           the PSRAM, busy/rdata/rdata_en back from it.
module ip_psram_arbiter
  import ip_psram_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_rdata_en,
  output logic                      timeout_err,
  output logic                      rd,
  output logic                      wr,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         wdata,
  input  logic                      busy,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      rdata_en
);

  state_t             state_q;
  logic [GNT_W-1:0]   grant_q;
  logic [GNT_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               seen_q;
  slot_t              slot_q [NUM_REQ];
  logic [NUM_REQ-1:0] req_busy_q;
  logic [NUM_REQ-1:0] req_rdata_en_q;
  logic [DATA_W-1:0]  req_rdata_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [ADDR_W-1:0]  address_q;
  logic               rd_q;
  logic               wr_q;
  logic               timeout_err_q;

  logic               rr_vld;
  logic [GNT_W-1:0]   rr_grant;
  slot_t              cur_slot;
  slot_t              rr_slot;
  logic               in_service;
  logic               rdata_vld;
  logic               done_ok;
  logic               timed_out;

  // In IDLE nothing is in service, so every busy slot is a pending request.
  ip_psram_arb_rr u_rr (
    .pending_i    (req_busy_q),
    .last_grant_i (last_grant_q),
    .grant_vld_o  (rr_vld),
    .grant_o      (rr_grant)
  );

  assign cur_slot   = slot_q[grant_q];
  assign rr_slot    = slot_q[rr_grant];
  assign in_service = (state_q == ST_HOLD) || (state_q == ST_WAIT);
  // Read data only counts while a read is outstanding; stray pulses elsewhere drop.
  assign rdata_vld  = in_service && rdata_en && !cur_slot.is_wr;
  // A read may finish in the same cycle its data arrives with busy already low.
  assign done_ok    = (state_q == ST_WAIT) && !busy &&
                      (cur_slot.is_wr || seen_q || rdata_vld);
  assign cnt_d      = cnt_q + 16'd1;
  assign timed_out  = (state_q == ST_WAIT) && !done_ok && (cnt_d == TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      last_grant_q   <= 2'd2;
      cnt_q          <= '0;
      seen_q         <= 1'b0;
      req_busy_q     <= '0;
      req_rdata_en_q <= '0;
      req_rdata_q    <= '0;
      wdata_q        <= '0;
      address_q      <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      timeout_err_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      req_rdata_en_q <= '0;

      // Slot capture; a read strobe wins over a simultaneous write strobe.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!req_busy_q[i] && (req_rd[i] || req_wr[i])) begin
          slot_q[i].is_wr <= !req_rd[i];
          slot_q[i].addr  <= req_address[i*ADDR_W +: ADDR_W];
          slot_q[i].wdata <= req_wdata[i*DATA_W +: DATA_W];
          req_busy_q[i]   <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (rr_vld) begin
            grant_q      <= rr_grant;
            last_grant_q <= rr_grant;
            rd_q         <= !rr_slot.is_wr;
            wr_q         <= rr_slot.is_wr;
            address_q    <= rr_slot.addr;
            wdata_q      <= rr_slot.wdata;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          cnt_q   <= '0;
          seen_q  <= 1'b0;
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          // busy may still reflect the previous access here, so it is not looked at.
          if (rdata_vld) begin
            seen_q      <= 1'b1;
            req_rdata_q <= rdata;
          end
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rdata_vld) begin
            seen_q      <= 1'b1;
            req_rdata_q <= rdata;
          end
          if (done_ok) begin
            req_busy_q[grant_q] <= 1'b0;
            if (!cur_slot.is_wr) begin
              req_rdata_en_q[grant_q] <= 1'b1;
            end
            state_q <= ST_IDLE;
          end else if (timed_out) begin
            req_busy_q[grant_q] <= 1'b0;
            timeout_err_q       <= 1'b1;
            if (!cur_slot.is_wr) begin
              req_rdata_q             <= '1;
              req_rdata_en_q[grant_q] <= 1'b1;
            end
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_busy     = req_busy_q;
  assign req_rdata    = req_rdata_q;
  assign req_rdata_en = req_rdata_en_q;
  assign timeout_err  = timeout_err_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign address      = address_q;
  assign wdata        = wdata_q;

endmodule

// File: doc/ip_psram_arbiter.md
IP_PSRAM_ARBITER -- requirements
Module: ip_psram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'd1024, maximum cycles the block waits in WAIT before forcing completion.
REQ-002 clk  input  1  system clock (53.685MHz domain); all logic on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_rd  input  3  per-requester read strobe; requester i uses bit i, one-cycle pulse.
REQ-005 req_wr  input  3  per-requester write strobe; bit i, one-cycle pulse.
REQ-006 req_address  input  66  three 22-bit addresses; requester i uses bits [22i+21:22i].
REQ-007 req_wdata  input  24  three 8-bit write data; requester i uses bits [8i+7:8i].
REQ-008 req_busy  output  3  bit i high while requester i has a request pending or in service.
REQ-009 req_rdata  output  8  read data returned to the serviced requester.
REQ-010 req_rdata_en  output  3  one-cycle pulse on bit i when req_rdata is valid for requester i.
REQ-011 timeout_err  output  1  sticky flag, set on any timeout.
REQ-012 rd, wr  output  1 each  one-cycle strobes to the PSRAM port.
REQ-013 address  output  22; wdata  output  8  PSRAM port address and write data.
REQ-014 busy  input  1; rdata  input  8; rdata_en  input  1  PSRAM port status and read return.

Function
REQ-015 Request capture: a strobe on bit i while req_busy[i]=0 SHALL latch rd/wr, address and wdata into slot i and set req_busy[i] on the next edge.
REQ-016 Strobes on bit i while req_busy[i]=1 SHALL be ignored; simultaneous req_rd[i] and req_wr[i] SHALL latch a read only.
REQ-017 States: IDLE, ISSUE, HOLD, WAIT; the state register SHALL be one-hot or binary, with no other states.
REQ-018 IDLE: when any slot is pending, the block SHALL grant by round-robin starting at (last_grant+1) mod 3 and go to ISSUE; last_grant SHALL reset to 2, so requester 0 wins first.
REQ-019 ISSUE (1 cycle): the block SHALL drive rd or wr=1 with the granted slot's address/wdata, then go to HOLD.
REQ-020 HOLD (1 cycle): the block SHALL ignore busy, then go to WAIT.
REQ-021 WAIT: for a write, the block SHALL complete when busy=0; for a read, it SHALL complete when busy=0 and rdata_en has been seen since ISSUE.
REQ-022 Read completion: the block SHALL capture rdata on rdata_en into req_rdata and pulse req_rdata_en[grant] exactly once.
REQ-023 Completion SHALL clear req_busy[grant] and return to IDLE; the next grant SHALL be issued no earlier than the cycle after IDLE.
REQ-024 Latency: a strobe at cycle t into an idle block SHALL produce rd/wr at t+2.
REQ-025 Timeout: a 16-bit counter SHALL clear on entry to HOLD and increment in WAIT. On reaching TIMEOUT, the block SHALL complete the operation, set timeout_err, and for reads return 8'hFF with req_rdata_en pulse.
REQ-026 rdata_en outside WAIT/HOLD SHALL be ignored.
REQ-027 address, wdata and req_rdata SHALL hold their last values when idle; rd and wr SHALL never be asserted together.

Reset
REQ-028 On reset, the block SHALL enter IDLE, clear all slots, and set req_busy=0, req_rdata_en=0, rd=wr=0, address=0, wdata=0, req_rdata=0, timeout_err=0, last_grant=2 and counter=0.
REQ-029 Reset mid-operation SHALL abandon the operation with no req_rdata_en pulse; the PSRAM port is assumed to be reset by the same reset.

Structure
REQ-030 A shared package SHALL hold the state encodings, NUM_REQ=3, ADDR_W=22 and DATA_W=8.
REQ-031 One sub-module, ip_psram_arb_rr (a 3-way round-robin grant from a pending vector and last_grant), SHALL be used; everything else is flat.

Verification
REQ-032 Single read: req_rd[0] with address 22'h000123; the model returns 8'h5A after 6 cycles of busy. Required: rd at t+2 with address 000123; req_rdata=5A; req_rdata_en=3'b001 pulse; req_busy[0] falls.
REQ-033 Contention: req_wr on all three requesters in the same cycle. Required: grants in order 0,1,2, one wr each with the matching wdata; a second round starting at 0 is also served in order 0,1,2.
REQ-034 Re-strobe while busy: req_rd[1] issued twice, 3 cycles apart. Required: exactly one rd on the PSRAM port.
REQ-035 Timeout: the model holds busy high forever after a read, with TIMEOUT=8. Required: completion 8 cycles after HOLD, req_rdata=FF, timeout_err=1.
REQ-036 Reset in WAIT: reset asserted mid-read. Required: all outputs return to reset values asynchronously; no req_rdata_en pulse; the block resumes service correctly after reset.
